// File: rtl/rng_arbiter_if.sv
// rng_arbiter_if -- requester-side bundle for rng_arbiter.
//   req       : per-requester level request for one random word
//   ack       : per-requester acknowledge of the delivered word
//   gnt       : one-hot (or zero) grant
//   rnd_out   : captured random word
//   rnd_valid : rnd_out valid for the granted requester
// master = requesters (drive req/ack), slave = arbiter.
// NREQ must match the NREQ of the rng_arbiter it is bound to.
interface rng_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rnd_out;
    logic            rnd_valid;

    modport master (output req, ack, input gnt, rnd_out, rnd_valid);
    modport slave  (input req, ack, output gnt, rnd_out, rnd_valid);
endinterface

// File: rtl/rng_arbiter.sv
// rng_arbiter -- round-robin arbiter sharing one LFSR random source.
// A winner is granted, the LFSR is stepped STEP_CYCLES times, the current
// LFSR word is captured and held for the winner until it acknowledges
// (or drops its request).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rng_arbiter_if.slave (req, ack in; gnt, rnd_out, rnd_valid out)
//   lfsr_rnd   : current random word from the LFSR
//   lfsr_en    : LFSR advance enable (decoded from state)
module rng_arbiter #(
    parameter int NREQ        = 4,
    parameter int STEP_CYCLES = 4,
    parameter int IDLE_RUN    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    rng_arbiter_if.slave  bus,
    input  logic [15:0]   lfsr_rnd,
    output logic          lfsr_en
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STEP    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DELIVER = 2'd3;

    logic [1:0]      state;
    logic [7:0]      cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_q;
    logic [NREQ-1:0] gnt_q;
    logic [15:0]     rnd_q;
    logic            valid_q;

    logic            any;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_after;
    logic            keep;

    assign bus.gnt       = gnt_q;
    assign bus.rnd_out   = rnd_q;
    assign bus.rnd_valid = valid_q;

    // Combinational so reset (which forces IDLE) immediately yields IDLE_RUN.
    assign lfsr_en = (state == ST_STEP) || ((state == ST_IDLE) && (IDLE_RUN != 0));

    // Pointer always moves one past the last winner, whether it was served
    // or withdrew.
    assign ptr_after = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
    assign keep      = bus.req[win_q];

    // Rotating search: first request at or above ptr, wrapping.
    always_comb begin
        int idx;
        idx = 0;
        any = 1'b0;
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && bus.req[idx[PW-1:0]]) begin
                any = 1'b1;
                win = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        gnt_q <= ONE << win;
                        win_q <= win;
                        cnt   <= 8'(STEP_CYCLES - 1);
                        state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (!keep) begin
                        gnt_q <= '0;
                        ptr   <= ptr_after;
                        state <= ST_IDLE;
                    end else if (cnt == 8'd0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    // A withdrawal seen here wins over the capture, so a
                    // requester that leaves never disturbs rnd_out.
                    if (!keep) begin
                        gnt_q <= '0;
                        ptr   <= ptr_after;
                        state <= ST_IDLE;
                    end else begin
                        rnd_q   <= lfsr_rnd;
                        valid_q <= 1'b1;
                        state   <= ST_DELIVER;
                    end
                end
                default: begin // ST_DELIVER
                    // ack and withdrawal both release; rnd_out keeps its value.
                    if (bus.ack[win_q] || !keep) begin
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        ptr     <= ptr_after;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
